scoring: RTL and testbench
==========================

# scoring

High-score bookkeeping block for the game datapath. Keeps a per-player best score for eight registered players plus an overall top score and its holder, and drives the address of the external UID_ROM so the holder's 4-digit user ID can be shown. Sits between the game controller (commands, BCD score) and the display digit drivers.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- controlSig  in  3  command: 000 IDLE, 001 RECORD, 010 SHOW_TOP, 011 SHOW_USER, 100 CLEAR_ALL; 101-111 behave as IDLE.
- isGuest  in  1  current player is a guest (no table entry).
- intIDin  in  3  internal player index 0-7.
- scoreOnes  in  4  BCD ones digit of the score being recorded.
- scoreTens  in  4  BCD tens digit of the score being recorded.
- topID  in  16  UID word returned by UID_ROM (four BCD digits, [15:12] most significant).
- intIDout  out  5  UID_ROM address.
- topIDOne/Two/Three/Four  out  4 each  UID digits: topID[3:0], [7:4], [11:8], [15:12].
- scoreOnesOut, scoreTensOut  out  4 each  displayed score, BCD.

## Operation
- Storage: 8-entry best-score table (tens, ones) indexed by intIDin; topScore (tens, ones); topAddr (5 bits).
- ROM address map: players 0-7 at addresses 0-7; guest at address 31.
- Input digits above 9 are saturated to 9 before any compare or store.
- Score compare: tens first, then ones; "greater" is strict. Ties never replace an existing entry or holder.
- RECORD, isGuest=0: if score > table[intIDin], write it. If score > topScore, set topScore=score, topAddr=intIDin. Outputs show the recorded score; intIDout=intIDin.
- RECORD, isGuest=1: table untouched; top handling per Configuration.
- SHOW_TOP: scoreTens/OnesOut=topScore; intIDout=topAddr.
- SHOW_USER: outputs table[intIDin]; intIDout=intIDin. With isGuest=1: score 00, intIDout=31.
- CLEAR_ALL: every table entry, topScore and topAddr set to 0; outputs 00, intIDout=0.
- IDLE/undefined: state and outputs hold.
- topIDOne-Four are combinational slices of topID; no registers.

## Timing
- All commands sampled on the rising clk edge; command lasts one cycle; back-to-back commands are allowed, each taking effect independently.
- Cycle N command -> table/top/score outputs/intIDout updated at edge N+1.
- UID_ROM has a registered output, so topID, and therefore topIDOne-Four, are valid after edge N+2.
- A RECORD followed immediately by SHOW_TOP shows the updated top value.
- Reset (rst=0 at an edge): table, topScore=00, topAddr=0, intIDout=0, scoreOnesOut=scoreTensOut=0. Reset wins over any command in the same cycle; reset mid-sequence discards the in-flight command.

## Configuration
- SCORING_GUEST_TOP_EN defined: a guest RECORD with score > topScore sets topScore=score and topAddr=31; outputs show the score and intIDout=31.
- Undefined: a guest RECORD changes no state; outputs show the score and intIDout=31.

## Test plan
- Reset, then SHOW_TOP -> outputs 0/0, intIDout=0; after 2 edges, digits equal ROM word 0.
- RECORD id=3 score 4/7 (tens/ones), then SHOW_TOP -> tens=4, ones=7, intIDout=3; next cycle topIDFour..One = ROM[3] digits.
- RECORD id=5 score 4/7 (tie), then SHOW_TOP -> holder stays 3. RECORD id=5 score 5/0 -> holder 5, top 5/0.
- RECORD id=5 score 2/0, then SHOW_USER id=5 -> 5/0 (best score kept). Input score 12/15 -> stored as 9/9.
- Guest RECORD 9/9: with the macro, SHOW_TOP -> 9/9, intIDout=31; without it, SHOW_TOP is unchanged.
- CLEAR_ALL, then SHOW_USER id=5 and SHOW_TOP -> 0/0, intIDout 5 and 0. rst asserted together with RECORD -> no store.

Source files
------------

// File: rtl/scoring.sv
// High-score bookkeeping: per-player best table, overall top score and holder.
// Optional SCORING_GUEST_TOP_EN lets guest records claim the top score.
module scoring (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] controlSig,
  input  logic       isGuest,
  input  logic [2:0] intIDin,
  input  logic [3:0] scoreOnes,
  input  logic [3:0] scoreTens,
  input  logic [15:0] topID,
  output logic [4:0] intIDout,
  output logic [3:0] topIDOne,
  output logic [3:0] topIDTwo,
  output logic [3:0] topIDThree,
  output logic [3:0] topIDFour,
  output logic [3:0] scoreOnesOut,
  output logic [3:0] scoreTensOut
);

  localparam logic [2:0] CMD_REC  = 3'b001;
  localparam logic [2:0] CMD_TOP  = 3'b010;
  localparam logic [2:0] CMD_USER = 3'b011;
  localparam logic [2:0] CMD_CLR  = 3'b100;
  localparam logic [4:0] GUEST    = 5'd31;

  // Scores held as {tens, ones}; with both digits <= 9 a plain
  // unsigned compare is the same as tens-first then ones.
  logic [7:0][7:0] tab_q, tab_d;
  logic [7:0]      top_q, top_d;
  logic [4:0]      addr_q, addr_d;
  logic [7:0]      out_q, out_d;
  logic [4:0]      id_q, id_d;
  logic [7:0]      score;
  logic [4:0]      pid;

  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign score = {sat9(scoreTens), sat9(scoreOnes)};
  assign pid   = {2'b00, intIDin};

  always_comb begin
    tab_d  = tab_q;
    top_d  = top_q;
    addr_d = addr_q;
    out_d  = out_q;
    id_d   = id_q;
    case (controlSig)
      CMD_REC: begin
        out_d = score;
        if (!isGuest) begin
          id_d = pid;
          if (score > tab_q[intIDin])
            tab_d[intIDin] = score;
          if (score > top_q) begin
            top_d  = score;
            addr_d = pid;
          end
        end else begin
          id_d = GUEST;
`ifdef SCORING_GUEST_TOP_EN
          if (score > top_q) begin
            top_d  = score;
            addr_d = GUEST;
          end
`endif
        end
      end
      CMD_TOP: begin
        out_d = top_q;
        id_d  = addr_q;
      end
      CMD_USER: begin
        if (isGuest) begin
          out_d = 8'h00;
          id_d  = GUEST;
        end else begin
          out_d = tab_q[intIDin];
          id_d  = pid;
        end
      end
      CMD_CLR: begin
        tab_d  = '0;
        top_d  = 8'h00;
        addr_d = 5'd0;
        out_d  = 8'h00;
        id_d   = 5'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tab_q  <= '0;
      top_q  <= 8'h00;
      addr_q <= 5'd0;
      out_q  <= 8'h00;
      id_q   <= 5'd0;
    end else begin
      tab_q  <= tab_d;
      top_q  <= top_d;
      addr_q <= addr_d;
      out_q  <= out_d;
      id_q   <= id_d;
    end
  end

  assign intIDout     = id_q;
  assign scoreTensOut = out_q[7:4];
  assign scoreOnesOut = out_q[3:0];
  assign topIDOne     = topID[3:0];
  assign topIDTwo     = topID[7:4];
  assign topIDThree   = topID[11:8];
  assign topIDFour    = topID[15:12];

endmodule

// File: tb/tb_scoring.sv
// Bench for scoring: directed test-plan steps then random commands,
// checked against an integer-score reference model and a UID_ROM model.
module tb_scoring;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  controlSig;
  logic        isGuest;
  logic [2:0]  intIDin;
  logic [3:0]  scoreOnes, scoreTens;
  logic [15:0] topID;
  logic [4:0]  intIDout;
  logic [3:0]  topIDOne, topIDTwo, topIDThree, topIDFour;
  logic [3:0]  scoreOnesOut, scoreTensOut;

  int vecs = 0;
  int errs = 0;

  int m_tab[8];
  int m_top, m_addr, m_out, m_id;
  int prev_id;
  bit prev_ok;

  scoring dut (
    .clk(clk), .rst(rst), .controlSig(controlSig), .isGuest(isGuest),
    .intIDin(intIDin), .scoreOnes(scoreOnes), .scoreTens(scoreTens),
    .topID(topID), .intIDout(intIDout),
    .topIDOne(topIDOne), .topIDTwo(topIDTwo),
    .topIDThree(topIDThree), .topIDFour(topIDFour),
    .scoreOnesOut(scoreOnesOut), .scoreTensOut(scoreTensOut)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] uid(input int a);
    return {4'((a + 1) % 10), 4'((a + 7) % 10), 4'(a / 10), 4'(a % 10)};
  endfunction

  // registered-output ROM
  always @(posedge clk) topID <= uid(int'(intIDout));

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    logic [7:0] es;
    es = {4'(m_out / 10), 4'(m_out % 10)};
    check("score", {8'h00, scoreTensOut, scoreOnesOut}, {8'h00, es});
    check("intIDout", {11'h0, intIDout}, 16'(m_id));
    if (prev_ok)
      check("uid_digits", {topIDFour, topIDThree, topIDTwo, topIDOne},
            uid(prev_id));
  endtask

  task automatic model_reset();
    foreach (m_tab[i]) m_tab[i] = 0;
    m_top = 0; m_addr = 0; m_out = 0; m_id = 0;
  endtask

  task automatic model_cmd(input int c, input bit g, input int id,
                           input int t, input int o);
    int s;
    s = (t > 9 ? 9 : t) * 10 + (o > 9 ? 9 : o);
    case (c)
      1: begin
        m_out = s;
        if (!g) begin
          m_id = id;
          if (s > m_tab[id]) m_tab[id] = s;
          if (s > m_top) begin m_top = s; m_addr = id; end
        end else begin
          m_id = 31;
`ifdef SCORING_GUEST_TOP_EN
          if (s > m_top) begin m_top = s; m_addr = 31; end
`endif
        end
      end
      2: begin m_out = m_top; m_id = m_addr; end
      3: begin
        if (g) begin m_out = 0; m_id = 31; end
        else begin m_out = m_tab[id]; m_id = id; end
      end
      4: begin model_reset(); end
      default: ;
    endcase
  endtask

  // called at a negedge; returns at the next negedge after checking
  task automatic step(input int c, input bit g, input int id,
                      input int t, input int o, input bit r = 1'b1);
    rst = r; controlSig = 3'(c); isGuest = g; intIDin = 3'(id);
    scoreTens = 4'(t); scoreOnes = 4'(o);
    prev_id = m_id;
    @(posedge clk);
    if (!r) model_reset();
    else model_cmd(c, g, id, t, o);
    @(negedge clk);
    check_outs();
    prev_ok = 1'b1;
  endtask

  initial begin
    prev_ok = 1'b0;
    m_id = 0;
    rst = 1'b0; controlSig = 3'd0; isGuest = 1'b0; intIDin = 3'd0;
    scoreTens = 4'd0; scoreOnes = 4'd0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1'b0);
    prev_ok = 1'b0;
    step(0, 0, 0, 0, 0, 1'b0);
    step(2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // first record and top readback
    step(1, 0, 3, 4, 7);
    step(2, 0, 0, 0, 0);
    check("top_holder3", {11'h0, intIDout}, 16'd3);
    step(0, 0, 0, 0, 0);
    // tie keeps holder, strict greater replaces
    step(1, 0, 5, 4, 7);
    step(2, 0, 0, 0, 0);
    check("tie_holder", {11'h0, intIDout}, 16'd3);
    step(1, 0, 5, 5, 0);
    step(2, 0, 0, 0, 0);
    check("new_holder", {11'h0, intIDout}, 16'd5);
    // lower score does not overwrite best
    step(1, 0, 5, 2, 0);
    step(3, 0, 5, 0, 0);
    check("best_kept", {8'h0, scoreTensOut, scoreOnesOut}, 16'h0050);
    // saturation
    step(1, 0, 2, 12, 15);
    check("saturate", {8'h0, scoreTensOut, scoreOnesOut}, 16'h0099);
    step(3, 0, 2, 0, 0);
    step(1, 0, 6, 9, 8);
    step(2, 0, 0, 0, 0);
    // guest record and guest show
    step(4, 0, 0, 0, 0);
    step(1, 1, 4, 9, 9);
    step(2, 0, 0, 0, 0);
    step(3, 1, 1, 0, 0);
    step(3, 0, 4, 0, 0);
    // clear
    step(1, 0, 5, 3, 3);
    step(4, 0, 0, 0, 0);
    step(3, 0, 5, 0, 0);
    step(2, 0, 0, 0, 0);
    step(7, 0, 1, 9, 9);
    // reset beats a concurrent record
    step(1, 0, 1, 8, 8);
    step(1, 0, 2, 6, 6, 1'b0);
    step(3, 0, 2, 0, 0);
    step(2, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      int c;
      c = int'($urandom_range(0, 7));
      if (c == 4 && $urandom_range(0, 3) != 0) c = 2;
      step(c, $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 60) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
